// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the instruction-fetch stage
package fetch_pkg;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL} state_t;
   localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for a returned word that ID could not take
module fetch_skid_buf
   import fetch_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              load,
   input  logic              drain,
   input  logic              clear,
   input  logic [31:0]       load_data,
   input  logic [ADDR_W-1:0] load_pc,
   output logic              valid,
   output logic [31:0]       data,
   output logic [ADDR_W-1:0] pc
);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         valid <= 1'b0;
         data  <= NOP_INST;
         pc    <= '0;
      end else begin
         if (clear || drain) valid <= 1'b0;
         else if (load) valid <= 1'b1;
         if (load) begin
            data <= load_data;
            pc   <= load_pc;
         end
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding instruction fetch and IF/ID register.
// Define FETCH_ADEL_CHECK_EN to trap misaligned fetch addresses instead of masking them.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] flush_pc_i,
   input  logic              redirect_valid_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_gnt,
   input  logic              inst_rvalid,
   input  logic [31:0]       inst_rdata,
   output logic              id_valid,
   output logic [31:0]       id_inst,
   output logic [ADDR_W-1:0] id_pc,
   output logic [ADDR_W-1:0] id_pc_plus8,
   output logic              id_adel
);
   state_t            state, nstate;
   logic [ADDR_W-1:0] fetch_pc, npc, req_pc, buf_pc, src_pc;
   logic [31:0]       buf_data, src_inst;
   logic              kill, nkill, accept, gnt_ok, rsp, buf_valid, adel_now, next_ok, has_word;

   assign accept   = !stall_i || !id_valid;
   assign gnt_ok   = state == S_IDLE && inst_req && inst_gnt;
   assign rsp      = state == S_WAIT && inst_rvalid && !kill;
   assign has_word = rsp || buf_valid || adel_now;
   assign src_inst = rsp ? inst_rdata : buf_valid ? buf_data : NOP_INST;
   assign src_pc   = rsp ? req_pc : buf_valid ? buf_pc : fetch_pc;

`ifdef FETCH_ADEL_CHECK_EN
   logic adel_done;
   assign adel_now  = state == S_IDLE && fetch_pc[1:0] != 2'b00 && !adel_done;
   assign next_ok   = npc[1:0] == 2'b00;
   assign inst_addr = fetch_pc;
   // the bad-address pseudo-instruction is delivered once, then fetch sits idle
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) adel_done <= 1'b0;
      else if (flush_i) adel_done <= 1'b0;
      else if (adel_now && accept) adel_done <= 1'b1;
   end
`else
   assign adel_now  = 1'b0;
   assign next_ok   = 1'b1;
   assign inst_addr = {fetch_pc[ADDR_W-1:2], 2'b00};
`endif

   fetch_skid_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk       (clk),
      .resetn    (resetn),
      .load      (rsp && !accept && !flush_i),
      .drain     (buf_valid && accept),
      .clear     (flush_i),
      .load_data (inst_rdata),
      .load_pc   (req_pc),
      .valid     (buf_valid),
      .data      (buf_data),
      .pc        (buf_pc)
   );

   // a request granted in the flush cycle, or still pending, must have its response dropped
   always_comb begin
      nstate = state;
      npc    = fetch_pc;
      nkill  = kill;
      if (flush_i) begin
         npc    = flush_pc_i;
         nkill  = gnt_ok || (state == S_WAIT && !inst_rvalid);
         nstate = nkill ? S_WAIT : S_IDLE;
      end else begin
         if (gnt_ok) begin
            npc    = fetch_pc + ADDR_W'(4);
            nstate = S_WAIT;
         end
         if (state == S_WAIT && inst_rvalid) begin
            nkill  = 1'b0;
            nstate = (kill || accept) ? S_IDLE : S_FULL;
         end
         if (state == S_FULL && accept) nstate = S_IDLE;
         if (redirect_valid_i) npc = redirect_pc_i;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         fetch_pc    <= RESET_PC;
         kill        <= 1'b0;
         inst_req    <= 1'b0;
         req_pc      <= '0;
         id_valid    <= 1'b0;
         id_inst     <= NOP_INST;
         id_pc       <= '0;
         id_pc_plus8 <= '0;
         id_adel     <= 1'b0;
      end else begin
         state    <= nstate;
         fetch_pc <= npc;
         kill     <= nkill;
         inst_req <= nstate == S_IDLE && next_ok;
         if (gnt_ok) req_pc <= inst_addr;
         if (flush_i) begin
            id_valid <= 1'b0;
            id_adel  <= 1'b0;
         end else if (accept) begin
            id_valid <= has_word;
            id_adel  <= adel_now;
            if (has_word) begin
               id_inst     <= src_inst;
               id_pc       <= src_pc;
               id_pc_plus8 <= src_pc + ADDR_W'(8);
            end
         end
      end
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the MIPS core.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Buffers returned words and presents the instruction to the decode stage, which splits op/rs/rt/func for the main decoder.
- Accepts branch/jump redirects from decode, honouring the MIPS branch delay slot, and stall/flush from the hazard unit.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset
ADDR_W, 32, PC/address width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
stall_i  in  1  hazard unit: hold ID outputs, accept no new instruction
flush_i  in  1  exception flush: kill ID, in-flight and buffered instruction
flush_pc_i  in  ADDR_W  fetch restart address when flush_i
redirect_valid_i  in  1  decode resolved taken branch/jump/jr/jal/jalr/bal
redirect_pc_i  in  ADDR_W  target address
inst_req  out  1  fetch request valid
inst_addr  out  ADDR_W  fetch address, word aligned
inst_gnt  in  1  memory accepted request this cycle
inst_rvalid  in  1  response valid
inst_rdata  in  32  response data
id_valid  out  1  ID holds a valid instruction
id_inst  out  32  instruction to decode
id_pc  out  ADDR_W  PC of id_inst
id_pc_plus8  out  ADDR_W  link value for jal/jalr/bal (id_pc+8, wraps mod 2^ADDR_W)
id_adel  out  1  address-error flag (see Optional Feature)

Behaviour:
- Reset values: fetch_pc=RESET_PC; inst_req=0; id_valid=0; id_inst=0; id_pc=0; id_pc_plus8=0; id_adel=0; buffer empty; FSM=S_IDLE.
- FSM states:
  - S_IDLE: inst_req=1, inst_addr=fetch_pc. On inst_gnt: fetch_pc+=4 and go to S_WAIT.
  - S_WAIT: one request outstanding, inst_req=0. On inst_rvalid:
    - if kill flag set: drop the word, clear the flag, go to S_IDLE;
    - else if ID can accept (!stall_i or !id_valid): load ID, go to S_IDLE;
    - else: write the 1-entry buffer, go to S_FULL.
  - S_FULL: buffer occupied, no request issued. When ID can accept: move buffer to ID, go to S_IDLE.
- ID register updates only when ID can accept. When !stall_i and no word is available, id_valid<=0 (bubble).
- Latency: best case inst_addr issued in cycle N with gnt, rvalid in N+1, id_valid in N+2. Throughput is one instruction per 2 cycles (single outstanding, by design).
- Redirect, delay slot:
  - redirect_valid_i is a 1-cycle pulse while the branch sits in ID; fetch_pc<=redirect_pc_i.
  - The in-flight or buffered word is the delay slot and is kept, never killed.
  - If redirect_valid_i and inst_gnt coincide in S_IDLE, the granted address is the delay slot and redirect_pc_i wins over fetch_pc+4.
- Flush:
  - flush_i has priority over redirect and stall.
  - id_valid<=0, buffer cleared, fetch_pc<=flush_pc_i.
  - In S_WAIT: set kill flag; the pending response is discarded.
  - In S_FULL: go to S_IDLE.
  - flush_i with inst_rvalid in the same cycle discards that word.
- stall_i has no effect on request issue in S_IDLE. At most one word is ever in flight plus buffered beyond ID.
- Reset mid-transaction: all state clears immediately. The memory is reset on the same resetn, so no stale rvalid arrives.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.

Optional Feature:
- FETCH_ADEL_CHECK_EN defined:
  - If fetch_pc[1:0]!=0, no memory request is made.
  - A pseudo-instruction enters ID with id_inst=0 (nop), id_adel=1, id_pc=bad address.
  - The FSM stays in S_IDLE until flush_i.
- Undefined: id_adel tied 0; inst_addr[1:0] forced to 0.

Decomposition:
- Package fetch_pkg: state encoding (S_IDLE, S_WAIT, S_FULL), RESET_PC default, NOP_INST=32'h0.
- Sub-module fetch_skid_buf: 1-entry data/pc buffer with valid, load, drain and clear.

Test Plan:
- Reset release, memory gnt always, rvalid 1 cycle later with 32'h2408_0001 -> inst_addr=BFC0_0000, id_inst=2408_0001, id_pc=BFC0_0000, id_pc_plus8=BFC0_0008 two cycles after issue.
- stall_i held 4 cycles while a response returns -> word held in buffer, id_* unchanged, no new inst_req until the buffer drains; then sequential PCs resume with none lost or duplicated.
- Redirect pulse to 0000_1000 with delay slot in flight at BFC0_0004 -> BFC0_0004 reaches ID, next inst_addr=0000_1000.
- flush_i with flush_pc_i=BFC0_0380 while in S_WAIT -> stale rvalid discarded, id_valid=0, next inst_addr=BFC0_0380.
- flush_i and redirect_valid_i in the same cycle -> flush target wins.
- With FETCH_ADEL_CHECK_EN, redirect to 0000_1002 -> no inst_req, id_adel=1, id_pc=0000_1002.
